display_scan_controller: RTL and testbench



---
 rtl/display_scan_controller.sv | 141 ++++++++++++++
 tb/tb_display_scan_controller.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_controller.sv
// Converts a 12-bit binary result to four BCD digits (sequential double-dabble)
// and time-multiplexes the committed digits onto an active-low 7-segment bus.
module display_scan_controller #(
    parameter int REFRESH_DIV   = 50000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] value,
    input  logic        value_valid,
    output logic        value_ready,
    output logic        conv_busy,
    output logic [15:0] bcd_value,
    output logic [6:0]  segments,
    output logic [3:0]  display_select
);

    localparam int             CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [11:0]   shift_q, shift_d;
    logic [15:0]   scratch_q, scratch_d;
    logic [15:0]   scratch_adj;
    logic [3:0]    iter_q, iter_d;
    logic [15:0]   bcd_d;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    digit;
    logic          lead_zero;
    logic [6:0]    seg_d;
    logic [3:0]    sel_d;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    // Handshake: a value is taken on any rising edge where value_valid and
    // value_ready are both high; value_ready is high only in IDLE, so requests
    // made while a conversion runs are neither captured nor queued.
    assign value_ready = (state_q == IDLE);
    assign conv_busy   = (state_q == SHIFT) || (state_q == DONE);

    always_comb begin
        scratch_adj = scratch_q;
        for (int i = 0; i < 4; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5)
                scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        iter_d    = iter_q;
        bcd_d     = bcd_value;
        case (state_q)
            IDLE: begin
                if (value_valid) begin
                    shift_d   = value;
                    scratch_d = '0;
                    iter_d    = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = {scratch_adj[14:0], shift_q[11]};
                shift_d   = {shift_q[10:0], 1'b0};
                iter_d    = iter_q + 4'd1;
                if (iter_q == 4'd11)
                    state_d = DONE;
            end
            DONE: begin
                bcd_d   = scratch_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Segments are decoded from the digits being committed this edge, so the
    // bus never lags bcd_value and always matches the select it is paired with.
    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        idx_d = (cnt_q == CNT_LAST) ? idx_q + 2'd1 : idx_q;
        digit = bcd_d[4*idx_d +: 4];
        case (idx_d)
            2'd1:    lead_zero = (bcd_d[15:4] == 12'h000);
            2'd2:    lead_zero = (bcd_d[15:8] == 8'h00);
            2'd3:    lead_zero = (bcd_d[15:12] == 4'h0);
            default: lead_zero = 1'b0;
        endcase
        seg_d = (BLANK_LEADING && lead_zero) ? 7'b1111111 : seg_decode(digit);
        sel_d = ~(4'b0001 << idx_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            shift_q        <= '0;
            scratch_q      <= '0;
            iter_q         <= '0;
            bcd_value      <= '0;
            cnt_q          <= '0;
            idx_q          <= '0;
            segments       <= 7'b1000000;
            display_select <= 4'b1110;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            scratch_q      <= scratch_d;
            iter_q         <= iter_d;
            bcd_value      <= bcd_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            segments       <= seg_d;
            display_select <= sel_d;
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: directed values, commit scoreboard and
// per-slot scan checks on a blanking and a non-blanking instance.
module tb_display_scan_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] value;
    logic        value_valid;

    logic        a_ready, a_busy, b_ready, b_busy;
    logic [15:0] a_bcd, b_bcd;
    logic [6:0]  a_seg, b_seg;
    logic [3:0]  a_sel, b_sel;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [15:0] exp_q[$];
    int          exp_cyc_q[$];

    display_scan_controller #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) u_a (
        .clk(clk), .reset(reset), .value(value), .value_valid(value_valid),
        .value_ready(a_ready), .conv_busy(a_busy), .bcd_value(a_bcd),
        .segments(a_seg), .display_select(a_sel)
    );

    display_scan_controller #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) u_b (
        .clk(clk), .reset(reset), .value(value), .value_valid(value_valid),
        .value_ready(b_ready), .conv_busy(b_busy), .bcd_value(b_bcd),
        .segments(b_seg), .display_select(b_sel)
    );

    // clock / cycle count
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] cur_sel(input bit use_b);
        return use_b ? b_sel : a_sel;
    endfunction

    function automatic logic [6:0] cur_seg(input bit use_b);
        return use_b ? b_seg : a_seg;
    endfunction

    function automatic int sel_index(input logic [3:0] s);
        case (s)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    // scoreboard monitor: a commit is the rising edge of value_ready
    bit prev_ready = 1'b1;
    int low_cnt    = 0;
    always @(negedge clk) begin
        if (reset) begin
            prev_ready = 1'b1;
            low_cnt    = 0;
        end else begin
            if (!a_ready) begin
                low_cnt++;
            end else if (!prev_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_commit", 32'(a_bcd), 32'hFFFF_FFFF);
                end else begin
                    logic [15:0] e;
                    int          ec;
                    e  = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    chk($sformatf("bcd_a_%04h", e), 32'(a_bcd), 32'(e));
                    chk($sformatf("bcd_b_%04h", e), 32'(b_bcd), 32'(e));
                    chk($sformatf("commit_cycle_%04h", e), 32'(cyc), 32'(ec));
                    chk($sformatf("ready_low_cycles_%04h", e), 32'(low_cnt), 32'd13);
                    chk($sformatf("busy_after_%04h", e), 32'(a_busy), 32'd0);
                end
                low_cnt = 0;
            end
            prev_ready = a_ready;
        end
    end

    // driver: presents v, waits (bounded) for ready, books the expected commit
    task automatic send(input logic [11:0] v, input logic [15:0] e);
        int n;
        @(negedge clk);
        value       = v;
        value_valid = 1'b1;
        n = 0;
        while (!a_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!a_ready) begin
            chk($sformatf("ready_timeout_%0d", v), 32'(a_ready), 32'd1);
            value_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        exp_cyc_q.push_back(cyc + 14);
        @(posedge clk);
        #1 value_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_scan(input string name, input bit use_b,
                              input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3);
        logic [6:0] exp_seg [4];
        logic [6:0] act;
        logic [3:0] sel;
        logic [3:0] seen;
        int idx, run, unstable;
        exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2; exp_seg[3] = e3;
        seen = '0;
        @(negedge clk);
        sel = cur_sel(use_b);
        run = 0;
        while (cur_sel(use_b) == sel && run < 40) begin
            @(negedge clk);
            run++;
        end
        chk({name, "_align"}, 32'(run < 40), 32'd1);
        for (int s = 0; s < 4; s++) begin
            sel      = cur_sel(use_b);
            idx      = sel_index(sel);
            act      = cur_seg(use_b);
            run      = 0;
            unstable = 0;
            while (cur_sel(use_b) == sel && run < 40) begin
                if (cur_seg(use_b) !== act) unstable++;
                run++;
                @(negedge clk);
            end
            chk($sformatf("%s_slot%0d_len", name, s), 32'(run), 32'd4);
            chk($sformatf("%s_slot%0d_stable", name, s), 32'(unstable), 32'd0);
            if (idx < 0) begin
                chk($sformatf("%s_slot%0d_select", name, s), 32'(sel), 32'hE);
            end else begin
                chk($sformatf("%s_seg%0d", name, idx), 32'(act), 32'(exp_seg[idx]));
                seen[idx] = 1'b1;
            end
        end
        chk({name, "_all_digits"}, 32'(seen), 32'hF);
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_ready, bad_busy, bad_bcd, bad_seg;
        reset       = 1'b1;
        value       = '0;
        value_valid = 1'b0;

        // reset state
        #12;
        chk("rst_ready", 32'(a_ready), 32'd1);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_bcd", 32'(a_bcd), 32'h0);
        chk("rst_select", 32'(a_sel), 32'hE);
        chk("rst_segments", 32'(a_seg), 32'h40);
        @(negedge clk);
        #2 reset = 1'b0;

        bad_ready = 0; bad_busy = 0; bad_bcd = 0; bad_seg = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (a_ready !== 1'b1) bad_ready++;
            if (a_busy !== 1'b0) bad_busy++;
            if (a_bcd !== 16'h0) bad_bcd++;
            if (b_seg !== 7'b1000000) bad_seg++;
        end
        chk("idle_ready_stable", 32'(bad_ready), 32'd0);
        chk("idle_busy_stable", 32'(bad_busy), 32'd0);
        chk("idle_bcd_stable", 32'(bad_bcd), 32'd0);
        chk("idle_noblank_seg_stable", 32'(bad_seg), 32'd0);
        check_scan("scan_reset", 1'b0, 7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111);

        send(12'd2468, 16'h2468);
        wait_drain("v2468");
        check_scan("scan_2468", 1'b0, 7'b0000000, 7'b0000010, 7'b0011001, 7'b0100100);

        send(12'd4095, 16'h4095);
        wait_drain("v4095");
        check_scan("scan_4095", 1'b0, 7'b0010010, 7'b0010000, 7'b1000000, 7'b0011001);

        send(12'd0, 16'h0000);
        wait_drain("v0");
        check_scan("scan_0_blank", 1'b0, 7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111);
        check_scan("scan_0_noblank", 1'b1, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);

        send(12'd34, 16'h0034);
        wait_drain("v34");
        check_scan("scan_34_blank", 1'b0, 7'b0011001, 7'b0110000, 7'b1111111, 7'b1111111);
        check_scan("scan_34_noblank", 1'b1, 7'b0011001, 7'b0110000, 7'b1000000, 7'b1000000);

        // 567 is held valid through the 1234 conversion
        send(12'd1234, 16'h1234);
        send(12'd567, 16'h0567);
        wait_drain("v1234_567");
        check_scan("scan_567", 1'b0, 7'b1111000, 7'b0000010, 7'b0010010, 7'b1111111);

        // reset at the 6th SHIFT iteration of 3000
        send(12'd3000, 16'h3000);
        repeat (6) @(posedge clk);
        #1 chk("abort_busy_before", 32'(a_busy), 32'd1);
        #1 reset = 1'b1;
        #1;
        exp_q.delete();
        exp_cyc_q.delete();
        chk("abort_ready", 32'(a_ready), 32'd1);
        chk("abort_busy", 32'(a_busy), 32'd0);
        chk("abort_bcd", 32'(a_bcd), 32'h0);
        chk("abort_select", 32'(a_sel), 32'hE);
        chk("abort_segments", 32'(a_seg), 32'h40);
        @(negedge clk);
        #2 reset = 1'b0;
        bad_bcd = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_bcd !== 16'h0) bad_bcd++;
        end
        chk("abort_bcd_stays_zero", 32'(bad_bcd), 32'd0);

        send(12'd5, 16'h0005);
        wait_drain("v5");
        check_scan("scan_5", 1'b0, 7'b0010010, 7'b1111111, 7'b1111111, 7'b1111111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
